// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter slice.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N       = 8;
    localparam int ARB_IDW     = 3;
    localparam int ARB_TIMEOUT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping,
// found with a double-width masked priority scan.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = ARB_N,
    parameter int IDW = ARB_IDW
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] id,
    output logic           any
);

    localparam int PW = IDW + 1;

    logic [2*N-1:0] masked_s;
    logic [PW-1:0]  pos_s;
    logic           found_s;

    // Low copy only sees requesters at or above ptr; high copy supplies the wrap.
    always_comb begin
        masked_s = {(2*N){1'b0}};
        for (int i = 0; i < N; i++) begin
            masked_s[i]     = req[i] & (IDW'(i) >= ptr);
            masked_s[N + i] = req[i];
        end
    end

    // Lowest set bit of the masked vector wins.
    always_comb begin
        found_s = 1'b0;
        pos_s   = {PW{1'b0}};
        for (int i = 0; i < 2 * N; i++) begin
            if (!found_s && masked_s[i]) begin
                found_s = 1'b1;
                pos_s   = PW'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Fold the scan position back into the requester index range.
    always_comb begin
        if (pos_s >= PW'(N)) begin
            id = IDW'(pos_s - PW'(N));
        end else begin
            id = pos_s[IDW-1:0];
        end
    end

    // One-hot form of the winning index, zero when nobody requests.
    always_comb begin
        onehot = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            onehot[i] = found_s && (id == IDW'(i));
        end
    end

    assign any = found_s;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and encoded id.
// Optional forced release after TIMEOUT grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N       = ARB_N,
    parameter int IDW     = ARB_IDW,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           busy,
    output logic           timeout_err
);

    if (N < 2 || IDW != $clog2(N) || TIMEOUT < 1) begin : g_param_err
        $error("rr_arbiter: N must be >= 2, IDW == clog2(N), TIMEOUT >= 1");
    end

    arb_state_t     state_r;
    logic [IDW-1:0] ptr_r;
    logic [N-1:0]   pick_onehot_s;
    logic [IDW-1:0] pick_id_s;
    logic           pick_any_s;
    logic [IDW-1:0] next_ptr_s;
    logic           release_s;
    logic           force_rel_s;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .onehot (pick_onehot_s),
        .id     (pick_id_s),
        .any    (pick_any_s)
    );

    // Pointer moves just past the winner so it becomes lowest priority next time.
    always_comb begin
        if (pick_id_s == IDW'(N - 1)) begin
            next_ptr_s = {IDW{1'b0}};
        end else begin
            next_ptr_s = pick_id_s + IDW'(1);
        end
    end

    // Holder lets go by pulsing done or by withdrawing its own request.
    always_comb begin
        release_s = done | ~req[gnt_id];
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_r;

    // Counts GRANT cycles; sits at zero while idle so each grant starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (state_r == ARB_GRANT) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= {TW{1'b0}};
        end
    end

    assign force_rel_s = (tmo_cnt_r == TW'(TIMEOUT - 1));
`else
    assign force_rel_s = 1'b0;
`endif

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ARB_IDLE;
            ptr_r       <= {IDW{1'b0}};
            gnt         <= {N{1'b0}};
            gnt_id      <= {IDW{1'b0}};
            gnt_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (pick_any_s) begin
                        gnt       <= pick_onehot_s;
                        gnt_id    <= pick_id_s;
                        gnt_valid <= 1'b1;
                        busy      <= 1'b1;
                        ptr_r     <= next_ptr_s;
                        state_r   <= ARB_GRANT;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_GRANT: begin
                    // A voluntary release on the deadline cycle is not an error.
                    if (release_s || force_rel_s) begin
                        gnt         <= {N{1'b0}};
                        gnt_valid   <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= ~release_s;
                        state_r     <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_GRANT;
                    end
                end
                default: begin
                    state_r   <= ARB_IDLE;
                    gnt       <= {N{1'b0}};
                    gnt_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed vector table, hold/timeout sequence,
// and randomized traffic against a behavioural model.
module tb_rr_arbiter;

    localparam int N   = 8;
    localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    rr_arbiter #(.N(N), .IDW(3), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .gnt_valid   (gnt_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] egnt;
        logic [2:0] eid;
        logic       ev;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic [7:0] q, logic d,
                                logic [7:0] eg, logic [2:0] eid, logic ev);
        vec_t v;
        v.rst = r; v.req = q; v.done = d;
        v.egnt = eg; v.eid = eid; v.ev = ev;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic [7:0] q, input logic d);
        rst = r; req = q; done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eg, input logic [2:0] eid,
                         input logic ev, input logic et);
        total++;
        if ({gnt, gnt_id, gnt_valid, busy, timeout_err} !== {eg, eid, ev, ev, et}) begin
            bad++;
            $display("FAIL %s: got gnt=%h id=%0d valid=%b busy=%b terr=%b, want gnt=%h id=%0d valid=%b busy=%b terr=%b",
                     name, gnt, gnt_id, gnt_valid, busy, timeout_err, eg, eid, ev, ev, et);
        end
    endtask

    // Behavioural model: who holds the resource, and where the rotation resumes.
    int         m_holder;
    int         m_ptr;
    int         m_held;
    logic [2:0] m_id;
    logic       m_terr;

    task automatic model_step(input logic r, input logic [7:0] q, input logic d);
        m_terr = 1'b0;
        if (r) begin
            m_holder = -1; m_ptr = 0; m_id = 3'd0; m_held = 0;
        end else if (m_holder < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (m_holder < 0 && q[idx]) m_holder = idx;
            end
            if (m_holder >= 0) begin
                m_id   = 3'(m_holder);
                m_ptr  = (m_holder + 1) % N;
                m_held = 0;
            end
        end else if (d || !q[m_holder]) begin
            m_holder = -1;
        end else begin
            m_held++;
            if (TMO_EN && m_held >= TMO) begin
                m_holder = -1;
                m_terr   = 1'b1;
            end
        end
    endtask

    initial begin
        logic [7:0] one;
        logic [7:0] q;
        logic       r;
        logic       d;
        one = 8'h01;
        rst = 1'b1; req = 8'h00; done = 1'b0;

        // Reset held with all requests, then first grant goes to 0.
        for (int i = 0; i < 3; i++) add(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0);
        add(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1);
        // Full rotation with done one cycle after each grant.
        for (int i = 1; i < N; i++) begin
            add(1'b0, 8'hFF, 1'b1, 8'h00, 3'(i - 1), 1'b0);
            add(1'b0, 8'hFF, 1'b0, one << i, 3'(i), 1'b1);
        end
        add(1'b0, 8'hFF, 1'b1, 8'h00, 3'd7, 1'b0);
        add(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1);
        // Wrap: grant 5 (ptr 6), then 8'h21 picks 0, then 5.
        add(1'b0, 8'h20, 1'b1, 8'h00, 3'd0, 1'b0);
        add(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1);
        add(1'b0, 8'h21, 1'b1, 8'h00, 3'd5, 1'b0);
        add(1'b0, 8'h21, 1'b0, 8'h01, 3'd0, 1'b1);
        add(1'b0, 8'h21, 1'b1, 8'h00, 3'd0, 1'b0);
        add(1'b0, 8'h21, 1'b0, 8'h20, 3'd5, 1'b1);
        // Other requesters never pre-empt the holder.
        add(1'b0, 8'hFF, 1'b0, 8'h20, 3'd5, 1'b1);
        add(1'b0, 8'h00, 1'b1, 8'h00, 3'd5, 1'b0);
        // Grant 3, then release by dropping the request; done in idle is inert.
        add(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1);
        add(1'b0, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0);
        // Reset mid-grant to 4, then rotation restarts at 0.
        add(1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1);
        add(1'b0, 8'hFF, 1'b0, 8'h10, 3'd4, 1'b1);
        add(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0);
        add(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].done);
            check($sformatf("vec%0d", i), vecs[i].egnt, vecs[i].eid, vecs[i].ev, 1'b0);
        end

        // Holder that never releases.
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b0, 8'h01, 1'b0);
        check("hold_start", 8'h01, 3'd0, 1'b1, 1'b0);
        if (TMO_EN) begin
            for (int c = 1; c < TMO; c++) begin
                drive(1'b0, 8'h01, 1'b0);
                check($sformatf("tmo_hold%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
            end
            drive(1'b0, 8'h01, 1'b0);
            check("tmo_force", 8'h00, 3'd0, 1'b0, 1'b1);
            drive(1'b0, 8'h01, 1'b0);
            check("tmo_regrant", 8'h01, 3'd0, 1'b1, 1'b0);
        end else begin
            for (int c = 1; c < 100; c++) begin
                drive(1'b0, 8'h01, 1'b0);
                check($sformatf("hold%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
            end
        end

        // Randomized traffic against the model.
        model_step(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        q = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: q = 8'hFF;
                    1: q = 8'h00;
                    2: q = one << $urandom_range(0, 7);
                    default: q = 8'($urandom);
                endcase
            end
            d = ($urandom_range(0, 4) == 0);
            model_step(r, q, d);
            drive(r, q, d);
            check($sformatf("rand%0d", c), (m_holder >= 0) ? (one << m_holder) : 8'h00,
                  m_id, (m_holder >= 0), m_terr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
